// File: rtl/vcve2_vrf_seq.sv
// Vector register file access sequencer feeding the vector AGU and ALU.
// Ports: start/use_* instruction handshake, busy/done status, AGU strobes
// (load/get_rs1/get_rs2/get_rd/incr), OBI-style data port, ALU operand/result.
module vcve2_vrf_seq #(
   parameter int unsigned WordsPerReg = 4,
   parameter int unsigned DataWidth   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 use_rs1_i,
   input  logic                 use_rs2_i,
   input  logic                 use_rd_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 load_o,
   output logic                 get_rs1_o,
   output logic                 get_rs2_o,
   output logic                 get_rd_o,
   output logic                 incr_o,
   output logic                 data_req_o,
   output logic                 data_we_o,
   input  logic                 data_gnt_i,
   input  logic                 data_rvalid_i,
   input  logic [DataWidth-1:0] data_rdata_i,
   output logic [DataWidth-1:0] data_wdata_o,
   output logic [DataWidth-1:0] op_a_o,
   output logic [DataWidth-1:0] op_b_o,
   output logic                 op_valid_o,
   input  logic [DataWidth-1:0] alu_result_i
);

   localparam int unsigned CntW = $clog2(WordsPerReg) + 1;
   localparam logic [CntW-1:0] LastWord = CntW'(WordsPerReg - 1);

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      REQ_A,
      WAIT_A,
      REQ_B,
      WAIT_B,
      EXEC,
      REQ_W,
      DONE
   } state_e;

   state_e state_q, state_d;
   state_e first_stage;
   state_e word_next;

   logic [CntW-1:0] cnt_q, cnt_d, cnt_next;
   logic use_rs1_q, use_rs2_q, use_rd_q;
   logic any_use;
   logic [DataWidth-1:0] op_a_q, op_b_q, wdata_q;

   assign any_use = use_rs1_q | use_rs2_q | use_rd_q;

   // Entry point of every word: first enabled read, else straight to EXEC.
   always_comb begin
      first_stage = EXEC;
      if (use_rs1_q) begin
         first_stage = REQ_A;
      end else if (use_rs2_q) begin
         first_stage = REQ_B;
      end
   end

   // Where to go once the current word has been fully processed.
   always_comb begin
      word_next = first_stage;
      cnt_next  = cnt_q + CntW'(1);
      if (cnt_q == LastWord) begin
         word_next = DONE;
         cnt_next  = cnt_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_o     = (state_q != IDLE);
      done_o     = 1'b0;
      load_o     = 1'b0;
      get_rs1_o  = 1'b0;
      get_rs2_o  = 1'b0;
      get_rd_o   = 1'b0;
      incr_o     = 1'b0;
      data_req_o = 1'b0;
      data_we_o  = 1'b0;
      op_valid_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_o  = 1'b1;
            cnt_d   = '0;
            state_d = any_use ? first_stage : DONE;
         end
         REQ_A: begin
            get_rs1_o  = 1'b1;
            data_req_o = 1'b1;
            incr_o     = data_gnt_i;
            if (data_gnt_i) begin
               state_d = WAIT_A;
            end
         end
         WAIT_A: begin
            if (data_rvalid_i) begin
               state_d = use_rs2_q ? REQ_B : EXEC;
            end
         end
         REQ_B: begin
            get_rs2_o  = 1'b1;
            data_req_o = 1'b1;
            incr_o     = data_gnt_i;
            if (data_gnt_i) begin
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (data_rvalid_i) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            op_valid_o = 1'b1;
            if (use_rd_q) begin
               state_d = REQ_W;
            end else begin
               state_d = word_next;
               cnt_d   = cnt_next;
            end
         end
         REQ_W: begin
            get_rd_o   = 1'b1;
            data_req_o = 1'b1;
            data_we_o  = 1'b1;
            incr_o     = data_gnt_i;
            // Write response (rvalid) is deliberately not awaited.
            if (data_gnt_i) begin
               state_d = word_next;
               cnt_d   = cnt_next;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         use_rs1_q <= 1'b0;
         use_rs2_q <= 1'b0;
         use_rd_q  <= 1'b0;
      end else if (state_q == IDLE && start_i) begin
         use_rs1_q <= use_rs1_i;
         use_rs2_q <= use_rs2_i;
         use_rd_q  <= use_rd_i;
      end
   end

   // Operands are cleared per instruction so an unused one reads as 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (state_q == LOAD) begin
            op_a_q <= '0;
            op_b_q <= '0;
         end
         if (state_q == WAIT_A && data_rvalid_i) begin
            op_a_q <= data_rdata_i;
         end
         if (state_q == WAIT_B && data_rvalid_i) begin
            op_b_q <= data_rdata_i;
         end
         if (state_q == EXEC) begin
            wdata_q <= alu_result_i;
         end
      end
   end

   assign op_a_o       = op_a_q;
   assign op_b_o       = op_b_q;
   assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_vcve2_vrf_seq.sv
// Self-checking bench for vcve2_vrf_seq: transaction-level model of the
// expected read/exec/write order per word, random memory timing, directed cases.
module tb_vcve2_vrf_seq;

   localparam int W  = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start = 1'b0;
   logic          use_rs1 = 1'b0;
   logic          use_rs2 = 1'b0;
   logic          use_rd = 1'b0;
   logic          busy_o, done_o, load_o;
   logic          get_rs1_o, get_rs2_o, get_rd_o, incr_o;
   logic          data_req_o, data_we_o;
   logic          gnt = 1'b0;
   logic          rvalid = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [DW-1:0] data_wdata_o, op_a_o, op_b_o;
   logic          op_valid_o;
   logic [DW-1:0] alu_result;

   always #5 clk = ~clk;

   assign alu_result = op_a_o + op_b_o;

   vcve2_vrf_seq #(
      .WordsPerReg(W),
      .DataWidth  (DW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .start_i      (start),
      .use_rs1_i    (use_rs1),
      .use_rs2_i    (use_rs2),
      .use_rd_i     (use_rd),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .load_o       (load_o),
      .get_rs1_o    (get_rs1_o),
      .get_rs2_o    (get_rs2_o),
      .get_rd_o     (get_rd_o),
      .incr_o       (incr_o),
      .data_req_o   (data_req_o),
      .data_we_o    (data_we_o),
      .data_gnt_i   (gnt),
      .data_rvalid_i(rvalid),
      .data_rdata_i (rdata),
      .data_wdata_o (data_wdata_o),
      .op_a_o       (op_a_o),
      .op_b_o       (op_b_o),
      .op_valid_o   (op_valid_o),
      .alu_result_i (alu_result)
   );

   int checks = 0;
   int failures = 0;

   // Model: expected event order, 1=read vs1, 2=read vs2, 3=exec, 4=write vd.
   int          q[$];
   bit          m_busy = 0;
   bit          m_first = 0;
   logic [31:0] cur_a = '0;
   logic [31:0] cur_b = '0;
   logic [31:0] exp_sum = '0;
   bit          pend = 0;
   int          pend_kind = 0;
   int          pend_dly = 0;
   bit          u1, u2, ud;

   int gnt_pct = 100;
   int max_dly = 0;
   bit stray = 0;
   bit fixed = 0;
   int hold_idx = -1;
   int hold_n = 0;
   int hold_cnt = 0;
   int txn_idx = 0;

   int cyc = 0;
   int start_cyc = 0;
   int done_cyc = 0;
   int n_incr, n_w33, n_txn, n_load, n_done, n_get1, n_hold;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic cycle(input bit st);
      int kind;
      bit was_busy;
      @(negedge clk);
      cyc++;
      if (data_req_o && txn_idx == hold_idx && hold_cnt < hold_n) begin
         gnt = 1'b0;
         hold_cnt++;
      end else begin
         gnt = ($urandom_range(99) < gnt_pct);
      end
      rvalid = 1'b0;
      rdata  = $urandom;
      if (pend) begin
         if (pend_dly == 0) begin
            rvalid = 1'b1;
            if (fixed) rdata = (pend_kind == 1) ? 32'h11 : 32'h22;
            if (pend_kind == 1) cur_a = rdata;
            else cur_b = rdata;
            pend = 0;
         end else begin
            pend_dly--;
         end
      end else if (stray && $urandom_range(7) == 0) begin
         rvalid = 1'b1;
      end
      start = st || (stray && m_busy && $urandom_range(4) == 0);
      if (stray && m_busy) begin
         {use_rs1, use_rs2, use_rd} = 3'($urandom);
      end else begin
         {use_rs1, use_rs2, use_rd} = {u1, u2, ud};
      end
      #1;
      chk("busy", busy_o, m_busy);
      chk("load", load_o, m_first);
      chk("incr", incr_o, data_req_o & gnt);
      chk("sel", $countones({get_rs1_o, get_rs2_o, get_rd_o}), data_req_o);
      if (incr_o) n_incr++;
      if (load_o) n_load++;
      if (get_rs1_o) n_get1++;
      if (data_req_o && !gnt && get_rs2_o) n_hold++;
      if (data_req_o && gnt) begin
         kind = get_rs1_o ? 1 : (get_rs2_o ? 2 : 4);
         n_txn++;
         txn_idx++;
         chk("txn_queue", q.size() > 0, 1);
         if (q.size() > 0) begin
            chk("txn_kind", kind, q[0]);
            chk("txn_we", data_we_o, q[0] == 4);
            if (q[0] == 4) begin
               chk("wdata", data_wdata_o, exp_sum);
               if (data_wdata_o == 32'h33) n_w33++;
            end
            void'(q.pop_front());
         end
         if (!data_we_o) begin
            pend      = 1;
            pend_kind = kind;
            pend_dly  = $urandom_range(max_dly);
         end
      end
      if (op_valid_o) begin
         chk("exec_order", q.size() > 0 && q[0] == 3 && !pend, 1);
         chk("op_a", op_a_o, cur_a);
         chk("op_b", op_b_o, cur_b);
         exp_sum = cur_a + cur_b;
         if (q.size() > 0 && q[0] == 3) void'(q.pop_front());
      end
      if (done_o) begin
         chk("done_when", m_busy && q.size() == 0 && !pend, 1);
         n_done++;
         done_cyc = cyc;
      end else if (!m_busy) begin
         chk("idle_quiet", {data_req_o, op_valid_o}, 0);
      end
      was_busy = m_busy;
      m_first  = 0;
      if (done_o) m_busy = 0;
      if (st && !was_busy) begin
         m_busy    = 1;
         m_first   = 1;
         start_cyc = cyc;
         cur_a     = '0;
         cur_b     = '0;
         txn_idx   = 0;
         hold_cnt  = 0;
         q.delete();
         if (u1 || u2 || ud) begin
            for (int w = 0; w < W; w++) begin
               if (u1) q.push_back(1);
               if (u2) q.push_back(2);
               q.push_back(3);
               if (ud) q.push_back(4);
            end
         end
      end
   endtask

   task automatic run_instr(input bit a, input bit b, input bit d, output int lat);
      u1 = a;
      u2 = b;
      ud = d;
      n_incr = 0; n_w33 = 0; n_txn = 0; n_load = 0;
      n_done = 0; n_get1 = 0; n_hold = 0;
      cycle(1);
      for (int i = 0; i < 3000 && m_busy; i++) cycle(0);
      if (m_busy) begin
         chk("timeout", m_busy, 0);
         m_busy = 0;
      end
      cycle(0);
      lat = done_cyc - start_cyc;
   endtask

   int lat;

   initial begin
      #12;
      chk("rst_ctl", {busy_o, done_o, load_o, get_rs1_o, get_rs2_o, get_rd_o,
                      incr_o, data_req_o, data_we_o, op_valid_o}, 0);
      chk("rst_opa", op_a_o, 0);
      chk("rst_wdata", data_wdata_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Zero-wait memory, fixed operands 0x11/0x22.
      fixed = 1;
      run_instr(1, 1, 1, lat);
      chk("t1_lat", lat, 26);
      chk("t1_writes33", n_w33, 4);
      chk("t1_incr", n_incr, 12);
      chk("t1_done", n_done, 1);
      chk("t1_load", n_load, 1);

      run_instr(0, 1, 1, lat);
      chk("t2_lat", lat, 18);
      chk("t2_get1", n_get1, 0);
      chk("t2_txn", n_txn, 8);

      hold_idx = 1;
      hold_n   = 3;
      run_instr(1, 1, 1, lat);
      chk("t3_lat", lat, 29);
      chk("t3_hold", n_hold, 3);
      chk("t3_incr", n_incr, 12);
      chk("t3_writes33", n_w33, 4);
      hold_idx = -1;
      hold_n   = 0;

      run_instr(0, 0, 0, lat);
      chk("t4_lat", lat, 2);
      chk("t4_load", n_load, 1);
      chk("t4_txn", n_txn, 0);
      chk("t4_done", n_done, 1);

      // Stray start/rvalid/use_* while busy must not disturb the sequence.
      stray = 1;
      run_instr(1, 1, 1, lat);
      chk("t5_lat", lat, 26);
      chk("t5_txn", n_txn, 12);
      chk("t5_writes33", n_w33, 4);
      stray = 0;

      // Abort in WAIT_B via asynchronous reset.
      u1 = 1; u2 = 1; ud = 1;
      cycle(1);
      for (int i = 0; i < 200 && !(pend && pend_kind == 2); i++) cycle(0);
      chk("pre_rst_wait_b", pend && pend_kind == 2, 1);
      @(negedge clk);
      gnt    = 1'b0;
      rvalid = 1'b0;
      start  = 1'b0;
      #2;
      chk("pre_rst_busy", busy_o, 1);
      chk("pre_rst_opa", op_a_o, 32'h11);
      rst_ni = 1'b0;
      #1;
      chk("arst_ctl", {busy_o, done_o, load_o, get_rs1_o, get_rs2_o, get_rd_o,
                       incr_o, data_req_o, data_we_o, op_valid_o}, 0);
      chk("arst_wdata", data_wdata_o, 0);
      chk("arst_opa", op_a_o, 0);
      chk("arst_opb", op_b_o, 0);
      m_busy  = 0;
      m_first = 0;
      pend    = 0;
      q.delete();
      @(negedge clk);
      rst_ni = 1'b1;
      n_done = 0;
      repeat (3) cycle(0);
      chk("rst_no_done", n_done, 0);
      run_instr(1, 1, 1, lat);
      chk("t6_lat", lat, 26);
      chk("t6_writes33", n_w33, 4);
      chk("t6_done", n_done, 1);

      // Random timing, data and instruction flags.
      fixed   = 0;
      gnt_pct = 60;
      max_dly = 3;
      stray   = 1;
      for (int k = 0; k < 30; k++) begin
         run_instr(1'($urandom), 1'($urandom), 1'($urandom), lat);
         chk("rnd_done", n_done, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
